// File: rtl/tl_pkg.sv
// tl_pkg: TileLink-UL opcode constants and the D-channel response record.
package tl_pkg;
  localparam int TL_DATA_W = 32;
  localparam int TL_SOURCE_W = 8;
  localparam logic [2:0] TL_GET = 3'd4;
  localparam logic [2:0] TL_PUT_FULL = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_ACK = 3'd0;
  localparam logic [2:0] TL_ACK_DATA = 3'd1;
  typedef struct packed {
    logic [2:0] opcode;
    logic [3:0] size;
    logic [TL_SOURCE_W-1:0] source;
    logic denied;
    logic [TL_DATA_W-1:0] data;
  } tl_d_bits_t;
endpackage

// File: rtl/tl_rsp_fifo.sv
// tl_rsp_fifo: first-word-fall-through queue of D-channel responses with occupancy count.
module tl_rsp_fifo
  import tl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  tl_d_bits_t i_data,
  input  logic i_pop,
  output logic o_valid,
  output tl_d_bits_t o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  tl_d_bits_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_pop;
  assign o_valid = r_count != '0;
  assign w_pop = i_pop && o_valid;
  // Empty queue presents all-zero fields rather than stale storage.
  assign o_data = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= (r_wr == AW'(DEPTH-1)) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= (r_rd == AW'(DEPTH-1)) ? '0 : r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/tl_ul_mem_responder.sv
// tl_ul_mem_responder: TileLink-UL manager backed by a word SRAM model with fixed
// latency and a credit-limited in-order response queue.
module tl_ul_mem_responder
  import tl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = TL_DATA_W,
  parameter int SOURCE_WIDTH = TL_SOURCE_W,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic a_valid,
  output logic a_ready,
  input  logic [2:0] a_bits_opcode,
  input  logic [2:0] a_bits_param,
  input  logic [3:0] a_bits_size,
  input  logic [SOURCE_WIDTH-1:0] a_bits_source,
  input  logic [ADDR_WIDTH-1:0] a_bits_address,
  input  logic [DATA_WIDTH/8-1:0] a_bits_mask,
  input  logic [DATA_WIDTH-1:0] a_bits_data,
  input  logic a_bits_corrupt,
  output logic d_valid,
  input  logic d_ready,
  output logic [2:0] d_bits_opcode,
  output logic [1:0] d_bits_param,
  output logic [3:0] d_bits_size,
  output logic [SOURCE_WIDTH-1:0] d_bits_source,
  output logic d_bits_sink,
  output logic d_bits_denied,
  output logic [DATA_WIDTH-1:0] d_bits_data,
  output logic d_bits_corrupt
);
  localparam int BW = DATA_WIDTH/8;
  localparam int OFF = $clog2(BW);
  localparam int IW = ADDR_WIDTH - OFF;
  localparam int MW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(QUEUE_DEPTH+1);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [CW-1:0] r_inflight, w_count;
  logic [CW:0] w_load;
  logic [IW-1:0] w_idx;
  logic w_in_range, w_get, w_put, w_fire, w_push, w_unused;
  tl_d_bits_t w_rsp, w_pipe_out, w_q_out;
  assign w_unused = ^{a_bits_param, a_bits_corrupt};
  assign w_idx = a_bits_address[ADDR_WIDTH-1:OFF];
  assign w_in_range = w_idx < IW'(DEPTH_WORDS);
  assign w_get = a_bits_opcode == TL_GET;
  assign w_put = a_bits_opcode == TL_PUT_FULL || a_bits_opcode == TL_PUT_PARTIAL;
  // Credits cover both the latency pipe and the queue, so pushes can never overflow.
  assign w_load = {1'b0, r_inflight} + {1'b0, w_count};
  assign a_ready = w_load < (CW+1)'(QUEUE_DEPTH);
  assign w_fire = a_valid && a_ready;
  assign w_rsp.opcode = w_get ? TL_ACK_DATA : TL_ACK;
  assign w_rsp.size = a_bits_size;
  assign w_rsp.source = a_bits_source;
  assign w_rsp.denied = !(w_in_range && (w_get || w_put));
  assign w_rsp.data = (w_get && w_in_range) ? r_mem[w_idx[MW-1:0]] : '0;
  always_ff @(posedge clock) begin
    if (w_fire && w_put && w_in_range)
      for (int b = 0; b < BW; b++)
        if (a_bits_mask[b]) r_mem[w_idx[MW-1:0]][b*8 +: 8] <= a_bits_data[b*8 +: 8];
  end
  // The queue's own register supplies the final cycle of latency.
  if (LATENCY == 1) begin : g_direct
    assign w_push = w_fire;
    assign w_pipe_out = w_rsp;
  end else begin : g_pipe
    logic [LATENCY-2:0] r_vld;
    tl_d_bits_t r_rsp [LATENCY-1];
    always_ff @(posedge clock or posedge reset) begin
      if (reset) r_vld <= '0;
      else begin
        r_vld[0] <= w_fire;
        for (int i = 1; i < LATENCY-1; i++) r_vld[i] <= r_vld[i-1];
      end
    end
    always_ff @(posedge clock) begin
      r_rsp[0] <= w_rsp;
      for (int i = 1; i < LATENCY-1; i++) r_rsp[i] <= r_rsp[i-1];
    end
    assign w_push = r_vld[LATENCY-2];
    assign w_pipe_out = r_rsp[LATENCY-2];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_inflight <= '0;
    else r_inflight <= r_inflight + CW'(w_fire) - CW'(w_push);
  end
  tl_rsp_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .i_clk(clock),
    .i_rst(reset),
    .i_push(w_push),
    .i_data(w_pipe_out),
    .i_pop(d_ready),
    .o_valid(d_valid),
    .o_data(w_q_out),
    .o_count(w_count)
  );
  assign d_bits_opcode = w_q_out.opcode;
  assign d_bits_param = '0;
  assign d_bits_size = w_q_out.size;
  assign d_bits_source = w_q_out.source;
  assign d_bits_sink = 1'b0;
  assign d_bits_denied = w_q_out.denied;
  assign d_bits_data = w_q_out.data;
  assign d_bits_corrupt = 1'b0;
endmodule
